witf: RTL and testbench
=======================

# witf

Write-in-flight table: an in-order scoreboard sitting beside IDU that answers its `isRAW` / `witf_full` queries. Each instruction dispatched from IDU into EX is pushed with its destination register; WBU pops the oldest entry when that instruction retires. IDU stalls while any in-flight entry targets its rs1/rs2, or while the table is full.

## Interface

Parameters:
- `DEPTH`, 4, number of in-flight entries (power of two, ≥2)
- `AW`, 5, register address width (`RegAddrBus`)

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset; asynchronous, active-low
- `flush_pipeline`  in  1  synchronous clear of all entries
- `rs1`  in  AW  source 1 of the instruction currently in IDU
- `rs2`  in  AW  source 2 of the instruction currently in IDU
- `disp_en`  in  1  push strobe: IDU latches an instruction into EX this cycle
- `rd`  in  AW  destination of the dispatched instruction
- `disp_wen`  in  1  dispatched instruction writes `rd` (its `RegWr`)
- `commit_en`  in  1  pop strobe: WBU retires the oldest instruction this cycle
- `isRAW`  out  1  hazard on rs1 or rs2 against a live entry
- `witf_full`  out  1  all DEPTH entries occupied
- `witf_empty`  out  1  no entries occupied
- `witf_cnt`  out  $clog2(DEPTH)+1  occupancy

## Operation

- Storage: DEPTH entries of {valid, wen, rd}; circular buffer with head (oldest) and tail pointers, each $clog2(DEPTH) bits, wrapping DEPTH-1 → 0; separate occupancy counter.
- Push: accepted when `disp_en` and (cnt < DEPTH or `commit_en`). Writes {1, disp_wen, rd} at tail; tail increments. Push while full without a same-cycle pop is dropped; cnt and entries unchanged. IDU must never do this, because it gates dispatch on `witf_full`.
- Every dispatched instruction is pushed, including non-writers (`disp_wen`=0), so pops stay in order with WBU retirements.
- Pop: accepted when `commit_en` and cnt > 0. Clears valid at head; head increments. Pop on empty is ignored.
- Simultaneous push and pop: both take effect; cnt unchanged. When full, the freed head slot makes room, so the push is accepted.
- Hazard match: an entry matches when valid and wen and rd != 0 and (rd == rs1 or rd == rs2). `isRAW` is the OR of all matches.
- `isRAW` is purely combinational from registered entries and the current `rs1`/`rs2`:
  - The instruction being pushed in this cycle is not compared against itself.
  - An entry popping this cycle still matches during that cycle.
- Comparisons do not consider whether the instruction actually reads rs2. A false RAW stall for U/J/I-type instructions is accepted as conservative.
- x0 never causes a hazard.
- Flush: `flush_pipeline` empties the table on the next edge: all valid bits, head, tail and cnt go to 0. Push and pop in the same cycle as a flush are discarded; flush wins.
- Flags:
  - `witf_full` = (cnt == DEPTH).
  - `witf_empty` = (cnt == 0).
  - Both are decoded from the registered cnt.

## Timing

- Reset (`rst`=0, async): all valid=0, head=tail=0, cnt=0. Outputs: `isRAW`=0, `witf_full`=0, `witf_empty`=1, `witf_cnt`=0. Release is synchronous to the next `clk` edge; the first push is accepted on the first edge after release.
- Push latency: an entry pushed at edge N affects `isRAW`/`witf_cnt`/`witf_full` from cycle N+1.
- Pop latency: an entry popped at edge N stops matching from cycle N+1. An instruction in IDU waiting on it dispatches no earlier than edge N+1.
- `isRAW` has zero-cycle latency from `rs1`/`rs2`.
- No combinational path exists from `disp_en`/`commit_en` to any output.
- Reset asserted mid-operation clears state immediately, regardless of strobes.

## Test plan

- Reset, then idle → `witf_empty`=1, `witf_cnt`=0, `isRAW`=0 for `rs1`=`rs2`=5.
- Push rd=5 with wen=1, then set rs1=5 → `isRAW`=1 from the next cycle. Pop → `isRAW`=0 the cycle after the pop edge. rs2=5 alone gives the same result.
- Push rd=0 with wen=1, and push rd=7 with wen=0 → rs1=0 and rs1=7 give `isRAW`=0; cnt=2.
- Push 4 times (DEPTH=4) → `witf_full`=1. A 5th `disp_en` without a pop is dropped (cnt stays 4). Push+pop while full → cnt stays 4 and the new rd is at the tail. Then run 8 further push+pop pairs to exercise pointer wrap; entry order is preserved, checked via `isRAW` per rd.
- Fill 3 entries, assert `flush_pipeline` together with `commit_en` and `disp_en` → next cycle cnt=0, `witf_empty`=1, `isRAW`=0.
- With 2 entries live, drop `rst` asynchronously mid-cycle → outputs reach reset values before the next edge. After release, a push is accepted normally.

Source files
------------

// File: rtl/witf_if.sv
// Write-in-flight table port bundle: IDU/WBU side (master) and the table (slave).
// No storage here; timing is set by the table.
// No flow control of its own; IDU backs off on witf_full.
interface witf_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 5
);
    logic                     flush_pipeline;
    logic [AW-1:0]            rs1;
    logic [AW-1:0]            rs2;
    logic                     disp_en;
    logic [AW-1:0]            rd;
    logic                     disp_wen;
    logic                     commit_en;
    logic                     isRAW;
    logic                     witf_full;
    logic                     witf_empty;
    logic [$clog2(DEPTH):0]   witf_cnt;

    modport master (
        output flush_pipeline, rs1, rs2, disp_en, rd, disp_wen, commit_en,
        input  isRAW, witf_full, witf_empty, witf_cnt
    );

    modport slave (
        input  flush_pipeline, rs1, rs2, disp_en, rd, disp_wen, commit_en,
        output isRAW, witf_full, witf_empty, witf_cnt
    );
endinterface

// File: rtl/witf.sv
// In-order write-in-flight scoreboard answering IDU RAW/full queries.
// Push/pop visible one cycle after the edge; isRAW is zero-latency from rs1/rs2.
// Push while full without a same-cycle pop is dropped; pop on empty is ignored.
module witf #(
    parameter int DEPTH = 4,
    parameter int AW    = 5
) (
    input  logic   clk,
    input  logic   rst,
    witf_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DEPTH-1:0] ent_vld;
    logic [DEPTH-1:0] ent_wen;
    logic [AW-1:0]    ent_rd [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    cnt;

    logic push_ok;
    logic pop_ok;
    logic raw;

    // A pop frees the head slot this edge, so a full table can still take a push.
    assign push_ok = bus.disp_en && ((cnt != FULL_CNT) || bus.commit_en);
    assign pop_ok  = bus.commit_en && (cnt != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_vld <= '0;
            ent_wen <= '0;
            for (int i = 0; i < DEPTH; i++) ent_rd[i] <= '0;
            head    <= '0;
            tail    <= '0;
            cnt     <= '0;
        end else if (bus.flush_pipeline) begin
            ent_vld <= '0;
            head    <= '0;
            tail    <= '0;
            cnt     <= '0;
        end else begin
            // Pop before push: when full, head == tail and the new entry must survive.
            if (pop_ok) begin
                ent_vld[head] <= 1'b0;
                head          <= head + 1'b1;
            end
            if (push_ok) begin
                ent_vld[tail] <= 1'b1;
                ent_wen[tail] <= bus.disp_wen;
                ent_rd[tail]  <= bus.rd;
                tail          <= tail + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_comb begin
        raw = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && ent_wen[i] && (ent_rd[i] != '0) &&
                ((ent_rd[i] == bus.rs1) || (ent_rd[i] == bus.rs2)))
                raw = 1'b1;
        end
    end

    assign bus.isRAW      = raw;
    assign bus.witf_full  = (cnt == FULL_CNT);
    assign bus.witf_empty = (cnt == '0);
    assign bus.witf_cnt   = cnt;
endmodule

// File: tb/tb_witf.sv
// Scoreboard bench for witf: stimulus queues expected outputs, a negedge monitor checks them.
module tb_witf;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    witf_if #(.DEPTH(4), .AW(5)) bus ();

    witf #(.DEPTH(4), .AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string    name;
        bit       raw;
        bit       full;
        bit       empty;
        int       cnt;
    } exp_t;

    typedef struct {
        logic [4:0] rd;
        bit         we;
    } ent_t;

    exp_t exp_q [$];
    ent_t model_q [$];
    int   n_vec = 0;
    int   n_err = 0;

    // Monitor: compares every queued expectation against the outputs mid-cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            if (bus.isRAW !== e.raw || bus.witf_full !== e.full ||
                bus.witf_empty !== e.empty || int'(bus.witf_cnt) != e.cnt) begin
                n_err++;
                $display("FAIL %s: got raw=%0b full=%0b empty=%0b cnt=%0d, want raw=%0b full=%0b empty=%0b cnt=%0d",
                         e.name, bus.isRAW, bus.witf_full, bus.witf_empty, bus.witf_cnt,
                         e.raw, e.full, e.empty, e.cnt);
            end
        end
    end

    task automatic drive(input bit de, input logic [4:0] rdv, input bit we, input bit ce,
                         input bit fl, input logic [4:0] r1, input logic [4:0] r2);
        @(posedge clk);
        #1;
        bus.disp_en        = de;
        bus.rd             = rdv;
        bus.disp_wen       = we;
        bus.commit_en      = ce;
        bus.flush_pipeline = fl;
        bus.rs1            = r1;
        bus.rs2            = r2;
    endtask

    task automatic exp_out(input string nm, input bit raw, input bit full, input bit empty,
                           input int cnt);
        exp_t e;
        e.name  = nm;
        e.raw   = raw;
        e.full  = full;
        e.empty = empty;
        e.cnt   = cnt;
        exp_q.push_back(e);
    endtask

    initial begin
        ent_t popped;
        ent_t pushed;

        bus.disp_en        = 1'b0;
        bus.rd             = '0;
        bus.disp_wen       = 1'b0;
        bus.commit_en      = 1'b0;
        bus.flush_pipeline = 1'b0;
        bus.rs1            = 5'd5;
        bus.rs2            = 5'd5;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        drive(0, 0, 0, 0, 0, 5, 5);   exp_out("reset_idle", 0, 0, 1, 0);
        drive(1, 5, 1, 0, 0, 5, 0);   exp_out("push_no_self", 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 5, 0);   exp_out("raw_rs1", 1, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 5);   exp_out("raw_rs2", 1, 0, 0, 1);
        drive(0, 0, 0, 1, 0, 5, 0);   exp_out("pop_cycle_match", 1, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 5, 5);   exp_out("after_pop", 0, 0, 1, 0);

        drive(1, 0, 1, 0, 0, 0, 0);   exp_out("push_x0", 0, 0, 1, 0);
        drive(1, 7, 0, 0, 0, 0, 0);   exp_out("x0_no_hazard", 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 7, 7);   exp_out("nonwriter_no_hazard", 0, 0, 0, 2);
        drive(1, 10, 1, 0, 0, 10, 0); exp_out("push_rd10", 0, 0, 0, 2);
        drive(1, 11, 1, 0, 0, 10, 0); exp_out("fill3", 1, 0, 0, 3);
        drive(0, 0, 0, 0, 0, 11, 0);  exp_out("full", 1, 1, 0, 4);
        drive(1, 12, 1, 0, 0, 12, 0); exp_out("push_when_full", 0, 1, 0, 4);
        drive(0, 0, 0, 0, 0, 12, 0);  exp_out("drop_when_full", 0, 1, 0, 4);
        drive(1, 13, 1, 1, 0, 13, 0); exp_out("push_pop_full_cycle", 0, 1, 0, 4);
        drive(0, 0, 0, 0, 0, 13, 0);  exp_out("push_pop_full", 1, 1, 0, 4);

        model_q.push_back('{rd: 5'd7,  we: 1'b0});
        model_q.push_back('{rd: 5'd10, we: 1'b1});
        model_q.push_back('{rd: 5'd11, we: 1'b1});
        model_q.push_back('{rd: 5'd13, we: 1'b1});
        for (int i = 0; i < 8; i++) begin
            popped    = model_q.pop_front();
            pushed.rd = 5'(20 + i);
            pushed.we = 1'b1;
            model_q.push_back(pushed);
            drive(1, pushed.rd, 1, 1, 0, popped.rd, 0);
            exp_out($sformatf("wrap_pop_match_%0d", i), popped.we && (popped.rd != 0), 1, 0, 4);
            drive(0, 0, 0, 0, 0, popped.rd, 0);
            exp_out($sformatf("wrap_popped_gone_%0d", i), 0, 1, 0, 4);
        end

        drive(0, 0, 0, 1, 0, 0, 0);    exp_out("pop_to_three", 0, 1, 0, 4);
        drive(0, 0, 0, 0, 0, 25, 0);   exp_out("three_live", 1, 0, 0, 3);
        drive(1, 30, 1, 1, 1, 25, 30); exp_out("flush_cycle", 1, 0, 0, 3);
        drive(0, 0, 0, 0, 0, 25, 30);  exp_out("flush_clears", 0, 0, 1, 0);

        drive(1, 5, 1, 0, 0, 0, 0);    exp_out("push5", 0, 0, 1, 0);
        drive(1, 6, 1, 0, 0, 0, 0);    exp_out("push6", 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 6, 0);    exp_out("two_live", 1, 0, 0, 2);
        drive(0, 0, 0, 0, 0, 6, 5);
        rst = 1'b0;                    exp_out("async_reset", 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 9, 0);
        rst = 1'b1;                    exp_out("reset_release", 0, 0, 1, 0);
        drive(1, 9, 1, 0, 0, 9, 0);    exp_out("push_after_reset", 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 9, 0);    exp_out("raw_after_reset", 1, 0, 0, 1);

        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
